// File: rtl/video_pkg.sv
// Shared timing defaults, pattern encodings and pixel type for the video pattern generator.
package video_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef enum logic [2:0] {
        PAT_BLACK    = 3'd0,
        PAT_BARS     = 3'd1,
        PAT_GRADIENT = 3'd2,
        PAT_GRID     = 3'd3,
        PAT_CHECKER  = 3'd4,
        PAT_WHITE    = 3'd5
    } pat_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam rgb888_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb888_t RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

    // Counters are kept at least min_w bits wide so pattern bit-slices always exist.
    function automatic int cnt_width(input int total, input int min_w);
        return ($clog2(total) > min_w) ? $clog2(total) : min_w;
    endfunction

    function automatic rgb888_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return '{r: 8'hFF, g: 8'hFF, b: 8'h00};
            3'd2:    return '{r: 8'h00, g: 8'hFF, b: 8'hFF};
            3'd3:    return '{r: 8'h00, g: 8'hFF, b: 8'h00};
            3'd4:    return '{r: 8'hFF, g: 8'h00, b: 8'hFF};
            3'd5:    return '{r: 8'hFF, g: 8'h00, b: 8'h00};
            3'd6:    return '{r: 8'h00, g: 8'h00, b: 8'hFF};
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters plus the first pipeline stage: de, syncs, x/y and start-of-frame flag.
module video_timing
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b1,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW       = cnt_width(H_TOTAL, 8),
    localparam int  YW       = cnt_width(V_TOTAL, 6)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_i,
    output logic          frame_end_o,
    output logic          de_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          sof_o,
    output logic [XW-1:0] x_o,
    output logic [5:0]    y_o
);

    logic [XW-1:0] h_cnt_q, h_cnt_d, x_q;
    logic [YW-1:0] v_cnt_q, v_cnt_d;
    logic [5:0]    y_q;
    logic          h_last, v_last;
    logic          de_d, hs_d, vs_d, sof_d;
    logic          de_q, hs_q, vs_q, sof_q;

    assign h_last      = (h_cnt_q == XW'(H_TOTAL - 1));
    assign v_last      = (v_cnt_q == YW'(V_TOTAL - 1));
    assign frame_end_o = ce_i && h_last && v_last;

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (ce_i) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    assign de_d  = (h_cnt_q < XW'(H_ACTIVE)) && (v_cnt_q < YW'(V_ACTIVE));
    assign hs_d  = ((h_cnt_q >= XW'(H_ACTIVE + H_FP)) &&
                    (h_cnt_q <  XW'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
    assign vs_d  = ((v_cnt_q >= YW'(V_ACTIVE + V_FP)) &&
                    (v_cnt_q <  YW'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
    assign sof_d = (h_cnt_q == '0) && (v_cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            sof_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so each register samples the pre-edge value of the others.
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (ce_i) begin
                x_q   <= h_cnt_q;
                y_q   <= v_cnt_q[5:0]; // patterns only look at y modulo 64
                de_q  <= de_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                sof_q <= sof_d;
            end
        end
    end

    assign de_o    = de_q;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;
    assign sof_o   = sof_q;
    assign x_o     = x_q;
    assign y_o     = y_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern source: raster timing plus a registered colour stage; pattern changes take effect per frame.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [2:0] pat_sel,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int XW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP, 8);

    logic          frame_end, de1, hs1, vs1, sof1;
    logic [XW-1:0] x1;
    logic [5:0]    y1;
    logic [2:0]    active_pat_q, bar_idx;
    logic [7:0]    frame_cnt_q;
    rgb888_t       pix_d, pix_q;
    logic          de_q, hs_q, vs_q, fs_q;

    video_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_i        (ce),
        .frame_end_o (frame_end),
        .de_o        (de1),
        .hsync_o     (hs1),
        .vsync_o     (vs1),
        .sof_o       (sof1),
        .x_o         (x1),
        .y_o         (y1)
    );

    always_comb begin
        pix_d   = RGB_BLACK;
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x1 >= XW'(k * H_ACTIVE / 8)) bar_idx = 3'(k);
        end
        if (de1) begin
            case (active_pat_q)
                PAT_BARS:     pix_d = bar_colour(bar_idx);
                PAT_GRADIENT: pix_d = '{r: x1[7:0], g: x1[7:0], b: x1[7:0] + frame_cnt_q};
                PAT_GRID:     pix_d = ((x1[4:0] == 5'd0) || (y1[4:0] == 5'd0)) ? RGB_WHITE : RGB_BLACK;
                PAT_CHECKER:  pix_d = (x1[5] ^ y1[5]) ? RGB_WHITE : RGB_BLACK;
                PAT_WHITE:    pix_d = RGB_WHITE;
                default:      pix_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_pat_q <= PAT_BLACK;
            frame_cnt_q  <= '0;
            pix_q        <= RGB_BLACK;
            de_q         <= 1'b0;
            hs_q         <= ~SYNC_POL;
            vs_q         <= ~SYNC_POL;
            fs_q         <= 1'b0;
        end else begin
            // Pattern and frame count both switch in vertical blanking, so a whole visible frame sees one value.
            if (frame_end) begin
                active_pat_q <= pat_sel;
                frame_cnt_q  <= frame_cnt_q + 1'b1;
            end
            if (ce) begin
                pix_q <= pix_d;
                de_q  <= de1;
                hs_q  <= hs1;
                vs_q  <= vs1;
                fs_q  <= sof1;
            end
        end
    end

    assign red         = pix_q.r;
    assign green       = pix_q.g;
    assign blue        = pix_q.b;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed/randomized bench for video_pattern_gen using a reduced raster and a pixel-index reference model.
module tb_video_pattern_gen;
    import video_pkg::*;

    localparam int   HA = 128, HFP = 4, HS = 8, HBP = 4;
    localparam int   VA = 40,  VFP = 2, VS = 3, VBP = 2;
    localparam int   HT = HA + HFP + HS + HBP;
    localparam int   VT = VA + VFP + VS + VBP;
    localparam int   FRAME = HT * VT;
    localparam logic POL = 1'b0;

    logic       clk = 1'b0;
    logic       reset_n, ce;
    logic [2:0] pat_sel;
    logic [7:0] red, green, blue;
    logic       de, hsync, vsync, frame_start;

    int checks = 0;
    int errors = 0;
    int edges  = 0;      // ce=1 clock edges since reset release
    int frame_pat [0:15];

    video_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (POL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .pat_sel     (pat_sel),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (ce edge %0d)", tag, obs, exp, edges);
        end
    endtask

    function automatic rgb888_t ref_colour(input int pat, input int x, input int y, input int f);
        logic [23:0] tbl [0:7];
        rgb888_t c;
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        c = '0;
        case (pat)
            1: c = rgb888_t'(tbl[x * 8 / HA]);
            2: begin
                c.r = 8'(x % 256);
                c.g = 8'(x % 256);
                c.b = 8'((x + f) % 256);
            end
            3: c = ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h0;
            4: c = (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
            5: c = 24'hFFFFFF;
            default: c = '0;
        endcase
        return c;
    endfunction

    // The output shows the pixel whose raster index is two ce edges behind.
    task automatic check_outputs();
        logic    e_de, e_hs, e_vs, e_fs;
        rgb888_t e_c;
        int      p, f, r, x, y, pat;
        e_de = 1'b0; e_hs = ~POL; e_vs = ~POL; e_fs = 1'b0; e_c = '0;
        if (edges >= 2) begin
            p    = edges - 2;
            f    = p / FRAME;
            r    = p % FRAME;
            x    = r % HT;
            y    = r / HT;
            pat  = (f == 0 || f > 15) ? 0 : frame_pat[f];
            e_de = (x < HA) && (y < VA);
            e_hs = (x >= HA + HFP && x < HA + HFP + HS) ? POL : ~POL;
            e_vs = (y >= VA + VFP && y < VA + VFP + VS) ? POL : ~POL;
            e_fs = (r == 0);
            e_c  = e_de ? ref_colour(pat, x, y, f % 256) : '0;
        end
        check_val("de",          {7'd0, de},          {7'd0, e_de});
        check_val("hsync",       {7'd0, hsync},       {7'd0, e_hs});
        check_val("vsync",       {7'd0, vsync},       {7'd0, e_vs});
        check_val("frame_start", {7'd0, frame_start}, {7'd0, e_fs});
        check_val("red",   red,   e_c.r);
        check_val("green", green, e_c.g);
        check_val("blue",  blue,  e_c.b);
    endtask

    task automatic step(input logic ce_v, input logic [2:0] sel);
        ce      = ce_v;
        pat_sel = sel;
        @(posedge clk);
        if (ce_v) begin
            edges++;
            if (edges % FRAME == 0 && edges / FRAME < 16) frame_pat[edges / FRAME] = sel;
        end
        @(negedge clk);
        check_outputs();
    endtask

    // mode 0: ce always 1; mode 1: random ce; mode 2: ce toggles 1,0,1,0
    task automatic run(input int n, input int mode, input logic [2:0] sel);
        int   done = 0;
        int   t    = 0;
        logic c;
        while (done < n) begin
            case (mode)
                0:       c = 1'b1;
                1:       c = ($urandom % 4) != 0;
                default: c = (t % 2) == 0;
            endcase
            t++;
            step(c, sel);
            if (c) done++;
        end
    endtask

    task automatic apply_reset();
        ce      = 1'b1;
        reset_n = 1'b0;
        #1;
        edges = 0;
        foreach (frame_pat[i]) frame_pat[i] = 0;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        ce      = 1'b0;
        pat_sel = 3'd0;
        foreach (frame_pat[i]) frame_pat[i] = 0;
        @(negedge clk);
        apply_reset();

        // Frame 0 stays black despite pat_sel=5; frame 1 white.
        run(FRAME, 0, 3'd5);
        run(FRAME, 0, 3'd1);
        // Frame 2 bars; selection moves to checkerboard at line 20 but only frame 3 shows it.
        run(20 * HT, 0, 3'd1);
        run(FRAME - 20 * HT, 0, 3'd4);
        // Frame 3 checkerboard under random ce; frame 4 gradient with ce toggling.
        run(FRAME, 1, 3'd2);
        run(FRAME, 2, 3'd3);
        // Frame 5 grid, aborted mid-frame by reset.
        run(20 * HT + 30, 1, 3'd0);
        apply_reset();
        // Restart: frame_start two ce edges after release, black frame 0, then gradient with frame count 1.
        run(FRAME + 300, 0, 3'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
